hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the 5-stage RV32I core. It detects load-use and ecall operand hazards and stalls IF/ID, and it flushes wrong-path instructions on taken branches and jumps. It selects EX-stage operand forwarding. It runs the halt sequence that drains the pipeline after a terminating `ecall` and then raises `is_halted`.

## Interface
- `DRAIN_CYCLES`, default 3: cycles spent in DRAIN so that EX, MEM and WB retire before the halt.
- `HALT_REG`, default 17: register checked by `ecall`.
- `clk` input 1: clock.
- `reset` input 1: reset, synchronous, active-high.
- `id_rs1`, `id_rs2` input 5: source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2` input 1: the ID instruction actually reads rs1 / rs2.
- `id_is_ecall` input 1: the ID instruction is `ecall`.
- `id_halt_val_eq10` input 1: the register-file value of x[HALT_REG] equals 10.
- `ex_rs1`, `ex_rs2` input 5: source registers in ID/EX.
- `ex_rd` input 5, `ex_mem_read` input 1, `ex_reg_write` input 1: ID/EX destination and control.
- `ex_taken` input 1: branch or jump in EX resolved as taken.
- `mem_rd` input 5, `mem_reg_write` input 1: EX/MEM destination and control.
- `wb_rd` input 5, `wb_reg_write` input 1: MEM/WB destination and control.
- `pc_write` output 1: enables the PC update.
- `if_id_write` output 1: enables the IF/ID load.
- `if_id_flush` output 1: loads a NOP (0x00000013) into IF/ID.
- `id_ex_bubble` output 1: zeroes the ID/EX control bits.
- `forward_a`, `forward_b` output 2: EX operand select. 00 selects the register file, 10 selects EX/MEM alu_out, 01 selects the MEM/WB write data.
- `is_halted` output 1: simulation finished.
- `stall_count` output 32: number of stall cycles.
- `flush_count` output 32: number of taken-redirect flushes.

## Operation
- FSM states: RUN, DRAIN, HALTED.
- Reset puts the FSM in RUN, sets the drain counter to 0 and clears both counters.
- RUN priority, highest first:
  1. **Flush.** When `ex_taken` is set: `pc_write`=1, `if_id_write`=1, `if_id_flush`=1, `id_ex_bubble`=1. Any hazard or ecall in ID is ignored because it is on the wrong path. `flush_count` increments.
  2. **Load-use.** Condition: `ex_mem_read`, `ex_rd`≠0, and `ex_rd` matches a used ID source. Action: `pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1.
  3. **Ecall operand.** Condition: `id_is_ecall`, and any of EX, MEM or WB has reg_write set with rd==HALT_REG. Action: the same stall as load-use.
  4. **Halt start.** Condition: `id_is_ecall`, `id_halt_val_eq10`, and no ecall hazard. Action: freeze (`pc_write`=0, `if_id_write`=0, `id_ex_bubble`=1), load the drain counter with DRAIN_CYCLES-1, and go to DRAIN.
  5. Otherwise: `pc_write`=1, `if_id_write`=1, `if_id_flush`=0, `id_ex_bubble`=0.
- An `ecall` with x[HALT_REG]≠10 is a NOP.
- `stall_count` increments every RUN cycle with `pc_write`=0, including the halt-start cycle. Both counters saturate at 0xFFFFFFFF.
- DRAIN: freeze outputs each cycle. The counter decrements; at 0 the FSM goes to HALTED. `ex_taken` is ignored.
- HALTED: freeze outputs and `is_halted`=1. The FSM stays in HALTED until reset. Counters hold.
- Forwarding is combinational and independent of state, shown here for operand A (B is identical using `ex_rs2`):
  - 10 when `mem_reg_write`, `mem_rd`≠0 and `mem_rd`==`ex_rs1`.
  - Otherwise 01 when `wb_reg_write`, `wb_rd`≠0 and `wb_rd`==`ex_rs1`.
  - Otherwise 00.
  - When both MEM and WB match, MEM wins.
- The register file must write in the first half-cycle or bypass internally. ID does not get WB-to-ID forwarding from this block.

## Timing
- All control outputs are combinational from the current state and inputs, with zero latency.
- Counters, FSM state and the drain counter update at posedge.
- Output values while `reset` is high or in the first cycle after reset: RUN behaviour, `is_halted`=0, counters 0.
- `is_halted` rises DRAIN_CYCLES+1 posedges after the halt-start cycle; for the default this is 4.
- Load-use stall lasts exactly one cycle. Afterwards the load is in MEM and forwarding selects 01 on the next cycle.
- Reset while in DRAIN or HALTED returns to RUN on the next posedge.

## Structure
- Shared package `hazard_pkg`:
  - FSM state enum (RUN=0, DRAIN=1, HALTED=2).
  - Forward-select constants FWD_RF, FWD_MEM, FWD_WB.
  - NOP_INST.
  - HALT_VALUE=10.
- One sub-module, `forwarding_unit`: combinational EX-operand select for one operand, instantiated twice.

## Test plan
- Run `lw x5,0(x0)`; `add x6,x5,x5` → one cycle with `pc_write`=0 and `id_ex_bubble`=1; next cycle `forward_a`=`forward_b`=01; `stall_count`=1.
- Run `addi x1,x0,3`; `addi x2,x1,1` → `forward_a`=10 with no stall; with one NOP between them, `forward_a`=01.
- Apply `ex_taken`=1 while ID holds `lw` with a load-use match → `if_id_flush`=1, `id_ex_bubble`=1, `pc_write`=1, no stall; `flush_count`=1.
- Run `addi x17,x0,10`; `ecall` → ecall stalls 3 cycles (EX, MEM, WB hazard), halt-start, 3 DRAIN cycles, then `is_halted`=1 and held for 100 cycles.
- Run `ecall` with x17=5 → no halt; the pipeline continues.
- Assert reset in HALTED → next cycle RUN, `is_halted`=0, counters 0, `pc_write`=1.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard / halt controller.
package hazard_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } hz_state_e;

    // EX operand source selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // addi x0, x0, 0 -- what IF/ID holds after a flush
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // x[HALT_REG] value that turns ecall into a halt request
    localparam logic [31:0] HALT_VALUE = 32'd10;

    // Saturating 32-bit increment for the event counters
    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/forwarding_unit.sv
// EX-stage operand source select for one operand. The younger producer
// (EX/MEM) takes precedence over MEM/WB; x0 is never forwarded.
module forwarding_unit
    import hazard_pkg::*;
(
    input  logic [4:0] ex_rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_reg_write,
    input  logic [4:0] wb_rd,
    input  logic       wb_reg_write,
    output logic [1:0] fwd_sel
);

    // Pick the most recent in-flight writer of ex_rs
    always_comb begin
        fwd_sel = FWD_RF;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
            fwd_sel = FWD_MEM;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
            fwd_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use / ecall-operand stalls, taken
// redirect flushes, EX forwarding selects and the ecall halt drain sequence.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned HALT_REG     = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        id_is_ecall,
    input  logic        id_halt_val_eq10,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_reg_write,
    input  logic        ex_taken,
    input  logic [4:0]  mem_rd,
    input  logic        mem_reg_write,
    input  logic [4:0]  wb_rd,
    input  logic        wb_reg_write,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic [1:0]  forward_a,
    output logic [1:0]  forward_b,
    output logic        is_halted,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
);

    localparam logic [4:0]  HALT_RD    = 5'(HALT_REG);
    localparam logic [31:0] DRAIN_LOAD = 32'(DRAIN_CYCLES - 1);

    hz_state_e   state_q, state_d, cur_state;
    logic [31:0] drain_q, drain_d;
    logic [31:0] stall_q, stall_d;
    logic [31:0] flush_q, flush_d;

    logic load_use;
    logic ecall_hazard;
    logic halt_start;
    logic run_flush;
    logic run_stall;

    // While reset is held the outputs behave as RUN regardless of the flop
    assign cur_state = reset ? RUN : state_q;

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    // ecall reads x[HALT_REG] straight from the register file, so any
    // in-flight writer of that register must retire first
    assign ecall_hazard = id_is_ecall &&
                          ((ex_reg_write  && (ex_rd  == HALT_RD)) ||
                           (mem_reg_write && (mem_rd == HALT_RD)) ||
                           (wb_reg_write  && (wb_rd  == HALT_RD)));

    assign halt_start = id_is_ecall && id_halt_val_eq10 && !ecall_hazard;

    // A taken redirect squashes ID, so its hazards do not count
    assign run_flush = (cur_state == RUN) && ex_taken;
    assign run_stall = (cur_state == RUN) && !ex_taken &&
                       (load_use || ecall_hazard || halt_start);

    // State register: FSM, drain counter and event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            drain_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    // Next-state logic: halt entry, drain countdown, counter updates
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        stall_d = stall_q;
        flush_d = flush_q;
        case (state_q)
            RUN: begin
                if (run_flush) begin
                    flush_d = sat_inc(flush_q);
                end
                if (run_stall) begin
                    stall_d = sat_inc(stall_q);
                end
                if (!ex_taken && !load_use && halt_start) begin
                    state_d = DRAIN;
                    drain_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                if (drain_q == '0) begin
                    state_d = HALTED;
                end else begin
                    drain_d = drain_q - 32'd1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Output logic: pipeline register enables and halt flag
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        case (cur_state)
            RUN: begin
                if (ex_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                end else if (load_use || ecall_hazard || halt_start) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                end
            end
            DRAIN, HALTED: begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
            default: begin
                pc_write = 1'b1;
            end
        endcase
    end

    assign is_halted   = (cur_state == HALTED);
    assign stall_count = reset ? 32'd0 : stall_q;
    assign flush_count = reset ? 32'd0 : flush_q;

    // Operand A and B selects share one implementation
    forwarding_unit u_fwd_a (
        .ex_rs         (ex_rs1),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_sel       (forward_a)
    );

    forwarding_unit u_fwd_b (
        .ex_rs         (ex_rs2),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .fwd_sel       (forward_b)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// Scenario bench for hazard_controller: each task drives pipeline stage
// contents cycle by cycle, queues the expected control vector, and checks
// it plus the event counters half a cycle later.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2, id_is_ecall, id_halt_val_eq10;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic        ex_mem_read, ex_reg_write, ex_taken;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_reg_write, wb_reg_write;
    logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, is_halted;
    logic [1:0]  forward_a, forward_b;
    logic [31:0] stall_count, flush_count;

    always #5 clk = ~clk;

    hazard_controller dut (
        .clk              (clk),
        .reset            (reset),
        .id_rs1           (id_rs1),
        .id_rs2           (id_rs2),
        .id_use_rs1       (id_use_rs1),
        .id_use_rs2       (id_use_rs2),
        .id_is_ecall      (id_is_ecall),
        .id_halt_val_eq10 (id_halt_val_eq10),
        .ex_rs1           (ex_rs1),
        .ex_rs2           (ex_rs2),
        .ex_rd            (ex_rd),
        .ex_mem_read      (ex_mem_read),
        .ex_reg_write     (ex_reg_write),
        .ex_taken         (ex_taken),
        .mem_rd           (mem_rd),
        .mem_reg_write    (mem_reg_write),
        .wb_rd            (wb_rd),
        .wb_reg_write     (wb_reg_write),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_ex_bubble     (id_ex_bubble),
        .forward_a        (forward_a),
        .forward_b        (forward_b),
        .is_halted        (is_halted),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, fwd_a, fwd_b, halted}
    logic [8:0] ctrl_obs;
    assign ctrl_obs = {pc_write, if_id_write, if_id_flush, id_ex_bubble,
                       forward_a, forward_b, is_halted};

    localparam logic [3:0] C_RUN    = 4'b1100;
    localparam logic [3:0] C_STALL  = 4'b0001;
    localparam logic [3:0] C_FLUSH  = 4'b1111;
    localparam logic [3:0] C_FREEZE = 4'b0001;

    typedef struct {
        string      name;
        logic [8:0] ctrl;
        int         stall_inc;
        int         flush_inc;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_stalls = 32'd0;
    logic [31:0] exp_flushes = 32'd0;

    task automatic push_exp(input string name, input logic [3:0] c,
                            input logic [1:0] fa, input logic [1:0] fb,
                            input logic h, input int si, input int fi);
        exp_t e;
        e.name      = name;
        e.ctrl      = {c, fa, fb, h};
        e.stall_inc = si;
        e.flush_inc = fi;
        sb_q.push_back(e);
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
        id_is_ecall = 1'b0; id_halt_val_eq10 = 1'b0;
        ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0;
        ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_taken = 1'b0;
        mem_rd = 5'd0; mem_reg_write = 1'b0; wb_rd = 5'd0; wb_reg_write = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            idle();
            reset = (c < 2);
            if (c < 2) push_exp("reset_hold", C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
            else       push_exp("reset_release", C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (ctrl_obs !== e.ctrl) begin
                bad++;
                $display("FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl);
            end
            total++;
            if (stall_count !== exp_stalls || flush_count !== exp_flushes) begin
                bad++;
                $display("FAIL %s counters got=%0d/%0d want=%0d/%0d", e.name,
                         stall_count, flush_count, exp_stalls, exp_flushes);
            end
            exp_stalls  = exp_stalls + 32'(e.stall_inc);
            exp_flushes = exp_flushes + 32'(e.flush_inc);
            $display("txn %s ctrl=%b stalls=%0d flushes=%0d", e.name, ctrl_obs, stall_count, flush_count);
            @(posedge clk); #1;
        end
    endtask

    // lw x5,0(x0); add x6,x5,x5 plus the rd=0 and unused-source corner cases
    task automatic test_load_use();
        exp_t e;
        for (int c = 0; c < 6; c++) begin
            idle();
            case (c)
                0: begin
                    id_rs1 = 5'd5; id_rs2 = 5'd5; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
                    ex_rd = 5'd5; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
                    push_exp("lu_stall", C_STALL, 2'b00, 2'b00, 1'b0, 1, 0);
                end
                1: begin
                    id_rs1 = 5'd5; id_rs2 = 5'd5; id_use_rs1 = 1'b1; id_use_rs2 = 1'b1;
                    mem_rd = 5'd5; mem_reg_write = 1'b1;
                    push_exp("lu_bubble_in_ex", C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
                end
                2: begin
                    ex_rs1 = 5'd5; ex_rs2 = 5'd5; ex_rd = 5'd6; ex_reg_write = 1'b1;
                    wb_rd = 5'd5; wb_reg_write = 1'b1;
                    push_exp("lu_fwd_wb", C_RUN, 2'b01, 2'b01, 1'b0, 0, 0);
                end
                3: begin
                    id_use_rs1 = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
                    push_exp("lu_rd_zero", C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
                end
                4: begin
                    id_rs1 = 5'd3; id_use_rs1 = 1'b1; id_rs2 = 5'd7;
                    ex_rd = 5'd7; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
                    push_exp("lu_rs2_unused", C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
                end
                default: begin
                    id_rs1 = 5'd3; id_use_rs1 = 1'b1; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
                    ex_rd = 5'd7; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
                    push_exp("lu_rs2_only", C_STALL, 2'b00, 2'b00, 1'b0, 1, 0);
                end
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (ctrl_obs !== e.ctrl) begin
                bad++;
                $display("FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl);
            end
            total++;
            if (stall_count !== exp_stalls || flush_count !== exp_flushes) begin
                bad++;
                $display("FAIL %s counters got=%0d/%0d want=%0d/%0d", e.name,
                         stall_count, flush_count, exp_stalls, exp_flushes);
            end
            exp_stalls  = exp_stalls + 32'(e.stall_inc);
            exp_flushes = exp_flushes + 32'(e.flush_inc);
            $display("txn %s ctrl=%b stalls=%0d flushes=%0d", e.name, ctrl_obs, stall_count, flush_count);
            @(posedge clk); #1;
        end
    endtask

    // addi x1,x0,3; addi x2,x1,1 back to back and with a NOP between
    task automatic test_forwarding();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            idle();
            case (c)
                0: begin
                    ex_rs1 = 5'd1; ex_rd = 5'd2; ex_reg_write = 1'b1;
                    mem_rd = 5'd1; mem_reg_write = 1'b1;
                    push_exp("fwd_mem", C_RUN, 2'b10, 2'b00, 1'b0, 0, 0);
                end
                1: begin
                    ex_rs1 = 5'd1; ex_rd = 5'd2; ex_reg_write = 1'b1;
                    mem_rd = 5'd0; mem_reg_write = 1'b1;
                    wb_rd = 5'd1; wb_reg_write = 1'b1;
                    push_exp("fwd_wb_after_nop", C_RUN, 2'b01, 2'b00, 1'b0, 0, 0);
                end
                2: begin
                    ex_rs1 = 5'd1; ex_rs2 = 5'd1;
                    mem_rd = 5'd1; mem_reg_write = 1'b1;
                    wb_rd = 5'd1; wb_reg_write = 1'b1;
                    push_exp("fwd_mem_wins", C_RUN, 2'b10, 2'b10, 1'b0, 0, 0);
                end
                default: begin
                    ex_rs2 = 5'd4;
                    mem_rd = 5'd4; mem_reg_write = 1'b0;
                    wb_rd = 5'd4; wb_reg_write = 1'b1;
                    push_exp("fwd_b_wb_only", C_RUN, 2'b00, 2'b01, 1'b0, 0, 0);
                end
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (ctrl_obs !== e.ctrl) begin
                bad++;
                $display("FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl);
            end
            total++;
            if (stall_count !== exp_stalls || flush_count !== exp_flushes) begin
                bad++;
                $display("FAIL %s counters got=%0d/%0d want=%0d/%0d", e.name,
                         stall_count, flush_count, exp_stalls, exp_flushes);
            end
            exp_stalls  = exp_stalls + 32'(e.stall_inc);
            exp_flushes = exp_flushes + 32'(e.flush_inc);
            $display("txn %s ctrl=%b stalls=%0d flushes=%0d", e.name, ctrl_obs, stall_count, flush_count);
            @(posedge clk); #1;
        end
    endtask

    // Taken redirect overrides a load-use hazard and a halting ecall in ID
    task automatic test_flush();
        exp_t e;
        for (int c = 0; c < 3; c++) begin
            idle();
            case (c)
                0: begin
                    ex_taken = 1'b1; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
                    ex_rd = 5'd5; ex_mem_read = 1'b1; ex_reg_write = 1'b1;
                    push_exp("flush_over_load_use", C_FLUSH, 2'b00, 2'b00, 1'b0, 0, 1);
                end
                1: begin
                    ex_taken = 1'b1; id_is_ecall = 1'b1; id_halt_val_eq10 = 1'b1;
                    push_exp("flush_over_ecall", C_FLUSH, 2'b00, 2'b00, 1'b0, 0, 1);
                end
                default: begin
                    push_exp("after_flush", C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
                end
            endcase
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (ctrl_obs !== e.ctrl) begin
                bad++;
                $display("FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl);
            end
            total++;
            if (stall_count !== exp_stalls || flush_count !== exp_flushes) begin
                bad++;
                $display("FAIL %s counters got=%0d/%0d want=%0d/%0d", e.name,
                         stall_count, flush_count, exp_stalls, exp_flushes);
            end
            exp_stalls  = exp_stalls + 32'(e.stall_inc);
            exp_flushes = exp_flushes + 32'(e.flush_inc);
            $display("txn %s ctrl=%b stalls=%0d flushes=%0d", e.name, ctrl_obs, stall_count, flush_count);
            @(posedge clk); #1;
        end
    endtask

    // ecall with x17=5 is a NOP
    task automatic test_ecall_nop();
        exp_t e;
        for (int c = 0; c < 2; c++) begin
            idle();
            if (c == 0) begin
                id_is_ecall = 1'b1;
                push_exp("ecall_nop", C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
            end else begin
                push_exp("ecall_nop_next", C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
            end
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (ctrl_obs !== e.ctrl) begin
                bad++;
                $display("FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl);
            end
            total++;
            if (stall_count !== exp_stalls || flush_count !== exp_flushes) begin
                bad++;
                $display("FAIL %s counters got=%0d/%0d want=%0d/%0d", e.name,
                         stall_count, flush_count, exp_stalls, exp_flushes);
            end
            exp_stalls  = exp_stalls + 32'(e.stall_inc);
            exp_flushes = exp_flushes + 32'(e.flush_inc);
            $display("txn %s ctrl=%b stalls=%0d flushes=%0d", e.name, ctrl_obs, stall_count, flush_count);
            @(posedge clk); #1;
        end
    endtask

    // addi x17,x0,10; ecall -> 3 hazard stalls, halt start, 3 drain, halted
    task automatic test_halt();
        exp_t e;
        for (int c = 0; c < 107; c++) begin
            idle();
            if (c == 0) begin
                id_is_ecall = 1'b1; ex_rd = 5'd17; ex_reg_write = 1'b1;
                push_exp("ecall_haz_ex", C_STALL, 2'b00, 2'b00, 1'b0, 1, 0);
            end else if (c == 1) begin
                id_is_ecall = 1'b1; mem_rd = 5'd17; mem_reg_write = 1'b1;
                push_exp("ecall_haz_mem", C_STALL, 2'b00, 2'b00, 1'b0, 1, 0);
            end else if (c == 2) begin
                id_is_ecall = 1'b1; wb_rd = 5'd17; wb_reg_write = 1'b1;
                push_exp("ecall_haz_wb", C_STALL, 2'b00, 2'b00, 1'b0, 1, 0);
            end else if (c == 3) begin
                id_is_ecall = 1'b1; id_halt_val_eq10 = 1'b1;
                push_exp("halt_start", C_STALL, 2'b00, 2'b00, 1'b0, 1, 0);
            end else if (c < 7) begin
                ex_taken = (c == 5);
                id_rs1 = 5'd9; id_use_rs1 = 1'b1; ex_rd = 5'd9; ex_mem_read = 1'b1;
                push_exp("drain", C_FREEZE, 2'b00, 2'b00, 1'b0, 0, 0);
            end else begin
                ex_taken = c[0];
                ex_rs1 = 5'd2; mem_rd = 5'd2; mem_reg_write = 1'b1;
                push_exp("halted", C_FREEZE, 2'b10, 2'b00, 1'b1, 0, 0);
            end
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (ctrl_obs !== e.ctrl) begin
                bad++;
                $display("FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl);
            end
            total++;
            if (stall_count !== exp_stalls || flush_count !== exp_flushes) begin
                bad++;
                $display("FAIL %s counters got=%0d/%0d want=%0d/%0d", e.name,
                         stall_count, flush_count, exp_stalls, exp_flushes);
            end
            exp_stalls  = exp_stalls + 32'(e.stall_inc);
            exp_flushes = exp_flushes + 32'(e.flush_inc);
            $display("txn %s ctrl=%b stalls=%0d flushes=%0d", e.name, ctrl_obs, stall_count, flush_count);
            @(posedge clk); #1;
        end
    endtask

    // Reset while HALTED returns to RUN with cleared counters
    task automatic test_reset_in_halted();
        exp_t e;
        for (int c = 0; c < 4; c++) begin
            idle();
            reset = (c == 0);
            if (c == 0) begin
                exp_stalls  = 32'd0;
                exp_flushes = 32'd0;
                push_exp("rst_in_halted", C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
            end else if (c == 1) begin
                push_exp("rst_back_to_run", C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
            end else if (c == 2) begin
                id_rs2 = 5'd8; id_use_rs2 = 1'b1; ex_rd = 5'd8; ex_mem_read = 1'b1;
                push_exp("rst_then_stall", C_STALL, 2'b00, 2'b00, 1'b0, 1, 0);
            end else begin
                push_exp("rst_final", C_RUN, 2'b00, 2'b00, 1'b0, 0, 0);
            end
            @(negedge clk);
            e = sb_q.pop_front();
            total++;
            if (ctrl_obs !== e.ctrl) begin
                bad++;
                $display("FAIL %s ctrl got=%b want=%b", e.name, ctrl_obs, e.ctrl);
            end
            total++;
            if (stall_count !== exp_stalls || flush_count !== exp_flushes) begin
                bad++;
                $display("FAIL %s counters got=%0d/%0d want=%0d/%0d", e.name,
                         stall_count, flush_count, exp_stalls, exp_flushes);
            end
            exp_stalls  = exp_stalls + 32'(e.stall_inc);
            exp_flushes = exp_flushes + 32'(e.flush_inc);
            $display("txn %s ctrl=%b stalls=%0d flushes=%0d", e.name, ctrl_obs, stall_count, flush_count);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        test_reset();
        test_load_use();
        test_forwarding();
        test_flush();
        test_ecall_nop();
        test_halt();
        test_reset_in_halted();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
